// File: rtl/alu_mon_pkg.sv
// Shared types, register offsets and snapshot widths for the ALU mismatch monitor.
// Used by alu_mismatch_monitor and, when ALU_MON_HIST_EN is defined, alu_mon_hist_fifo.
package alu_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        TRIPPED = 2'd2
    } mon_state_t;

    localparam logic [7:0] ADR_CTRL       = 8'h00;
    localparam logic [7:0] ADR_STATUS     = 8'h04;
    localparam logic [7:0] ADR_MIS_CNT    = 8'h08;
    localparam logic [7:0] ADR_SMP_CNT    = 8'h0C;
    localparam logic [7:0] ADR_FIRST_FAIL = 8'h10;
    localparam logic [7:0] ADR_HIST       = 8'h14;

    localparam int CTRL_ARM_BIT = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam int ALU_W      = 4;
    // {out1, out2, c1, c2} ahead of the sample count in FIRST_FAIL
    localparam int SNAP_ALU_W = 2 * ALU_W + 2;
    // {out1, out2, c1, c2, x, y}: the six fields add up to 15 bits
    localparam int HIST_W     = 3 * ALU_W + 3;

    function automatic logic [HIST_W-1:0] hist_entry(
        input logic [ALU_W-1:0] out1,
        input logic [ALU_W-1:0] out2,
        input logic             c1,
        input logic             c2,
        input logic [ALU_W-1:0] x,
        input logic             y
    );
        return {out1, out2, c1, c2, x, y};
    endfunction

endpackage

// File: rtl/alu_mon_wb_if.sv
// Wishbone slave bus between the management core and the ALU mismatch monitor.
interface alu_mon_wb_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/alu_mon_hist_fifo.sv
// Small synchronous FIFO of mismatch snapshots with a show-ahead head entry.
// Only compiled and instantiated when ALU_MON_HIST_EN is defined.
`ifdef ALU_MON_HIST_EN
module alu_mon_hist_fifo #(
    parameter int W     = 15,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         empty,
    output logic         full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (PTR_W + 1)'(DEPTH));
    // a pop in the same cycle frees the slot the push needs
    assign do_push   = push & ~flush & (~full | pop);
    assign do_pop    = pop & ~flush & ~empty;
    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PTR_W + 1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W + 1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule
`endif

// File: rtl/alu_mismatch_monitor.sv
// Watches the dual ALU outputs, counts mismatches, trips after a run of them and serves
// counters over Wishbone. Define ALU_MON_HIST_EN to add the mismatch history FIFO at 0x14.
module alu_mismatch_monitor
    import alu_mon_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter int          TRIP_RUN = 4,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             en_i,
    input  logic [ALU_W-1:0] alu_out1_i,
    input  logic [ALU_W-1:0] alu_out2_i,
    input  logic             carry1_i,
    input  logic             carry2_i,
    input  logic [ALU_W-1:0] x_i,
    input  logic             y_i,
    alu_mon_wb_if.slave      wbs,
    output logic             err_o,
    output logic             irq_o
);
    localparam int               SNAP_W     = SNAP_ALU_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [3:0]       TRIP_RUN_L = 4'(TRIP_RUN);

    logic             valid_reg;
    logic [ALU_W-1:0] out1_reg, out2_reg, x_reg;
    logic             c1_reg, c2_reg, y_reg;
    logic             mis, fault;

    mon_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  mis_cnt_reg, mis_cnt_next, mis_cnt_inc;
    logic [CNT_W-1:0]  smp_cnt_reg, smp_cnt_next, smp_cnt_inc;
    logic [3:0]        run_reg, run_next, run_inc;
    logic [SNAP_W-1:0] first_fail_reg, first_fail_next;
    logic              ff_valid_reg, ff_valid_next;
    logic              fault_reg, fault_next;
    logic              irq_reg, irq_next;

    logic        ack_reg;
    logic [31:0] dat_reg, rdata_next;
    logic [7:0]  off;
    logic        adr_hit, wb_req, rd_req, ctrl_wr, clr_wr, arm_wr, count_en;
    logic        ovf;
    logic [31:0] hist_rdata;
    logic        unused_bits;

    // Stage 1: capture the ALU side only on qualified cycles
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            valid_reg <= 1'b0;
            out1_reg  <= '0;
            out2_reg  <= '0;
            c1_reg    <= 1'b0;
            c2_reg    <= 1'b0;
            x_reg     <= '0;
            y_reg     <= 1'b0;
        end else begin
            valid_reg <= en_i;
            if (en_i) begin
                out1_reg <= alu_out1_i;
                out2_reg <= alu_out2_i;
                c1_reg   <= carry1_i;
                c2_reg   <= carry2_i;
                x_reg    <= x_i;
                y_reg    <= y_i;
            end
        end
    end

    assign mis   = (out1_reg != out2_reg) || (c1_reg != c2_reg);
    assign fault = (x_reg != (out1_reg ^ out2_reg)) || (y_reg != (c1_reg ^ c2_reg));

    assign off      = wbs.wbs_adr_i[7:0];
    assign adr_hit  = (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign wb_req   = wbs.wbs_stb_i & wbs.wbs_cyc_i & ~ack_reg;
    assign rd_req   = wb_req & ~wbs.wbs_we_i;
    assign ctrl_wr  = wb_req & wbs.wbs_we_i & adr_hit & (off == ADR_CTRL);
    assign clr_wr   = ctrl_wr & wbs.wbs_dat_i[CTRL_CLR_BIT];
    assign arm_wr   = ctrl_wr & wbs.wbs_dat_i[CTRL_ARM_BIT];
    assign count_en = ~clr_wr & (state_reg == ARMED) & valid_reg;

    assign mis_cnt_inc = (mis_cnt_reg == '1) ? mis_cnt_reg : mis_cnt_reg + CNT_ONE;
    assign smp_cnt_inc = (smp_cnt_reg == '1) ? smp_cnt_reg : smp_cnt_reg + CNT_ONE;
    assign run_inc     = (run_reg == TRIP_RUN_L) ? run_reg : run_reg + 4'd1;

    always_comb begin
        state_next      = state_reg;
        mis_cnt_next    = mis_cnt_reg;
        smp_cnt_next    = smp_cnt_reg;
        run_next        = run_reg;
        first_fail_next = first_fail_reg;
        ff_valid_next   = ff_valid_reg;
        fault_next      = fault_reg;
        if (clr_wr) begin
            state_next      = arm_wr ? ARMED : IDLE;
            mis_cnt_next    = '0;
            smp_cnt_next    = '0;
            run_next        = '0;
            first_fail_next = '0;
            ff_valid_next   = 1'b0;
            fault_next      = 1'b0;
        end else begin
            if (valid_reg && fault) begin
                fault_next = 1'b1;
            end
            if (state_reg == IDLE && arm_wr) begin
                state_next = ARMED;
            end
            if (count_en) begin
                smp_cnt_next = smp_cnt_inc;
                if (mis) begin
                    mis_cnt_next = mis_cnt_inc;
                    run_next     = run_inc;
                    // snapshot carries the 1-based ordinal of the failing sample
                    if (!ff_valid_reg) begin
                        first_fail_next = {out1_reg, out2_reg, c1_reg, c2_reg, smp_cnt_inc};
                        ff_valid_next   = 1'b1;
                    end
                    if (run_inc == TRIP_RUN_L) begin
                        state_next = TRIPPED;
                    end
                end else begin
                    run_next = '0;
                end
            end
        end
        irq_next = (state_next == TRIPPED) && (state_reg != TRIPPED);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg      <= IDLE;
            mis_cnt_reg    <= '0;
            smp_cnt_reg    <= '0;
            run_reg        <= '0;
            first_fail_reg <= '0;
            ff_valid_reg   <= 1'b0;
            fault_reg      <= 1'b0;
            irq_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            mis_cnt_reg    <= mis_cnt_next;
            smp_cnt_reg    <= smp_cnt_next;
            run_reg        <= run_next;
            first_fail_reg <= first_fail_next;
            ff_valid_reg   <= ff_valid_next;
            fault_reg      <= fault_next;
            irq_reg        <= irq_next;
        end
    end

    assign err_o = (state_reg == TRIPPED);
    assign irq_o = irq_reg;

`ifdef ALU_MON_HIST_EN
    logic              hist_push, hist_pop, hist_empty, hist_full, ovf_reg;
    logic [HIST_W-1:0] hist_wdata, hist_head;

    assign hist_push  = count_en & mis;
    assign hist_pop   = rd_req & adr_hit & (off == ADR_HIST) & ~hist_empty;
    assign hist_wdata = hist_entry(out1_reg, out2_reg, c1_reg, c2_reg, x_reg, y_reg);

    alu_mon_hist_fifo #(
        .W     (HIST_W),
        .DEPTH (4)
    ) u_hist_fifo (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .flush     (clr_wr),
        .push      (hist_push),
        .push_data (hist_wdata),
        .pop       (hist_pop),
        .head_data (hist_head),
        .empty     (hist_empty),
        .full      (hist_full)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_wr) begin
            ovf_reg <= 1'b0;
        end else if (hist_push && hist_full && !hist_pop) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ovf        = ovf_reg;
    assign hist_rdata = hist_empty ? 32'h0 : {1'b1, {(31 - HIST_W){1'b0}}, hist_head};
`else
    assign ovf        = 1'b0;
    assign hist_rdata = 32'h0;
`endif

    always_comb begin
        rdata_next = 32'h0;
        if (adr_hit) begin
            case (off)
                ADR_STATUS:     rdata_next = 32'({ovf, fault_reg, err_o, state_reg});
                ADR_MIS_CNT:    rdata_next = 32'(mis_cnt_reg);
                ADR_SMP_CNT:    rdata_next = 32'(smp_cnt_reg);
                ADR_FIRST_FAIL: rdata_next = 32'(first_fail_reg);
                ADR_HIST:       rdata_next = hist_rdata;
                default:        rdata_next = 32'h0;
            endcase
        end
    end

    // ack_reg in wb_req keeps a held strobe from being acked on consecutive cycles
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_reg <= 1'b0;
            dat_reg <= 32'h0;
        end else begin
            ack_reg <= wb_req;
            dat_reg <= rd_req ? rdata_next : 32'h0;
        end
    end

    assign wbs.wbs_ack_o = ack_reg;
    assign wbs.wbs_dat_o = dat_reg;

    assign unused_bits = ^{wbs.wbs_sel_i, wbs.wbs_dat_i[31:2]};

endmodule

// File: tb/tb_alu_mismatch_monitor.sv
// Directed bench for alu_mismatch_monitor: default instance plus a CNT_W=4/TRIP_RUN=15 instance.
// Define ALU_MON_HIST_EN to also check the history FIFO.
module tb_alu_mismatch_monitor;
    import alu_mon_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        srst;
    logic        en;
    logic [3:0]  out1, out2, xv;
    logic        c1, c2, yv;
    logic        err, irq, err2, irq2;
    int          n_checks = 0;
    int          n_errors = 0;
    int          irq_pulses = 0;
    logic [31:0] rd;
    logic        ack_seen;

    alu_mon_wb_if wb ();
    alu_mon_wb_if wb2 ();

    always #5 clk = ~clk;

    alu_mismatch_monitor dut (
        .wb_clk_i (clk), .wb_rst_i (srst), .en_i (en),
        .alu_out1_i (out1), .alu_out2_i (out2), .carry1_i (c1), .carry2_i (c2),
        .x_i (xv), .y_i (yv), .wbs (wb.slave), .err_o (err), .irq_o (irq)
    );

    alu_mismatch_monitor #(.CNT_W (4), .TRIP_RUN (15)) dut2 (
        .wb_clk_i (clk), .wb_rst_i (srst), .en_i (en),
        .alu_out1_i (out1), .alu_out2_i (out2), .carry1_i (c1), .carry2_i (c2),
        .x_i (xv), .y_i (yv), .wbs (wb2.slave), .err_o (err2), .irq_o (irq2)
    );

    always @(negedge clk) if (irq) irq_pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic wb_xfer(input bit second, input bit we, input logic [31:0] adr,
                           input logic [31:0] wdata, output logic [31:0] rdata, output logic ack);
        if (!second) begin
            wb.wbs_adr_i = adr; wb.wbs_dat_i = wdata; wb.wbs_we_i = we;
            wb.wbs_sel_i = 4'hF; wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1;
        end else begin
            wb2.wbs_adr_i = adr; wb2.wbs_dat_i = wdata; wb2.wbs_we_i = we;
            wb2.wbs_sel_i = 4'hF; wb2.wbs_stb_i = 1'b1; wb2.wbs_cyc_i = 1'b1;
        end
        @(posedge clk); #1;
        ack   = second ? wb2.wbs_ack_o : wb.wbs_ack_o;
        rdata = second ? wb2.wbs_dat_o : wb.wbs_dat_o;
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb2.wbs_stb_i = 1'b0; wb2.wbs_cyc_i = 1'b0; wb2.wbs_we_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input bit second, input logic [7:0] off, input logic [31:0] data);
        wb_xfer(second, 1'b1, BASE | 32'(off), data, rd, ack_seen);
        $display("wb%0d write 0x%02h <= 0x%08h", second ? 2 : 1, off, data);
    endtask

    task automatic rd_chk(input bit second, input logic [7:0] off, input logic [31:0] exp,
                          input string tag);
        wb_xfer(second, 1'b0, BASE | 32'(off), 32'h0, rd, ack_seen);
        check(tag, rd, exp);
    endtask

    task automatic smp(input logic [3:0] a, input logic [3:0] b, input logic ca, input logic cb,
                       input logic [3:0] xx, input logic yy);
        out1 = a; out2 = b; c1 = ca; c2 = cb; xv = xx; yv = yy; en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic smp_mis(input logic [3:0] a, input logic [3:0] b);
        smp(a, b, 1'b0, 1'b0, a ^ b, 1'b0);
    endtask

    task automatic idle(input int n);
        en = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        srst = 1'b1; en = 1'b0;
        out1 = '0; out2 = '0; c1 = 1'b0; c2 = 1'b0; xv = '0; yv = 1'b0;
        wb.wbs_stb_i = 0; wb.wbs_cyc_i = 0; wb.wbs_we_i = 0; wb.wbs_sel_i = '0;
        wb.wbs_adr_i = '0; wb.wbs_dat_i = '0;
        wb2.wbs_stb_i = 0; wb2.wbs_cyc_i = 0; wb2.wbs_we_i = 0; wb2.wbs_sel_i = '0;
        wb2.wbs_adr_i = '0; wb2.wbs_dat_i = '0;
        repeat (3) @(posedge clk);
        #1;
        srst = 1'b0;

        // reset state and ack timing with a held strobe
        check("rst_err", 32'(err), 0);
        check("rst_irq", 32'(irq), 0);
        wb.wbs_adr_i = BASE | 32'(ADR_STATUS); wb.wbs_we_i = 1'b0;
        wb.wbs_stb_i = 1'b1; wb.wbs_cyc_i = 1'b1;
        @(posedge clk); #1;
        check("ack_next_cycle", 32'(wb.wbs_ack_o), 1);
        check("rst_status", wb.wbs_dat_o, 0);
        @(posedge clk); #1;
        check("ack_not_twice", 32'(wb.wbs_ack_o), 0);
        wb.wbs_stb_i = 1'b0; wb.wbs_cyc_i = 1'b0;
        @(posedge clk); #1;
        rd_chk(0, ADR_MIS_CNT, 0, "rst_mis_cnt");
        rd_chk(0, ADR_SMP_CNT, 0, "rst_smp_cnt");

        // ten matching samples
        wr(0, ADR_CTRL, 32'h1);
        repeat (10) smp(4'h5, 4'h5, 1'b0, 1'b0, 4'h0, 1'b0);
        idle(2);
        rd_chk(0, ADR_SMP_CNT, 10, "eq_smp_cnt");
        rd_chk(0, ADR_MIS_CNT, 0, "eq_mis_cnt");
        rd_chk(0, ADR_STATUS, 32'h1, "eq_status");
        check("eq_err", 32'(err), 0);

        // clear lands on the same edge as a stage-2 mismatch: clear wins
        smp_mis(4'h3, 4'h5);
        en = 1'b0;
        wr(0, ADR_CTRL, 32'h3);
        idle(1);
        rd_chk(0, ADR_SMP_CNT, 0, "clrwin_smp_cnt");
        rd_chk(0, ADR_MIS_CNT, 0, "clrwin_mis_cnt");

        // 3 mismatches, 1 match, 4 mismatches: trips on the 8th sample
        irq_pulses = 0;
        smp(4'h3, 4'h5, 1'b1, 1'b0, 4'h6, 1'b1);
        smp_mis(4'h9, 4'h2);
        smp_mis(4'h9, 4'h2);
        smp(4'h7, 4'h7, 1'b1, 1'b1, 4'h0, 1'b0);
        repeat (4) smp_mis(4'h9, 4'h2);
        en = 1'b0;
        check("trip_err_1cyc", 32'(err), 0);
        @(posedge clk); #1;
        check("trip_err_2cyc", 32'(err), 1);
        check("trip_irq_on", 32'(irq), 1);
        @(posedge clk); #1;
        check("trip_irq_off", 32'(irq), 0);
        smp_mis(4'h1, 4'h2);
        smp_mis(4'h1, 4'h2);
        idle(2);
        rd_chk(0, ADR_MIS_CNT, 7, "trip_mis_cnt");
        rd_chk(0, ADR_SMP_CNT, 8, "trip_smp_cnt");
        rd_chk(0, ADR_FIRST_FAIL, 32'h00D6_0001, "trip_first_fail");
        rd_chk(0, ADR_STATUS, 32'h6, "trip_status");
        check("trip_irq_pulses", 32'(irq_pulses), 1);

        // base miss, unmapped offset and dropped writes
        wb_xfer(0, 1'b0, 32'h4000_0008, 32'h0, rd, ack_seen);
        check("miss_rd_data", rd, 0);
        check("miss_rd_ack", 32'(ack_seen), 1);
        rd_chk(0, 8'h18, 0, "unmapped_rd");
        wb_xfer(0, 1'b1, 32'h3100_0000, 32'h3, rd, ack_seen);
        wr(0, ADR_STATUS, 32'h3);
        rd_chk(0, ADR_MIS_CNT, 7, "miss_wr_dropped");
        rd_chk(0, ADR_STATUS, 32'h6, "ro_wr_dropped");

        // compare fault: sticky in any state, cleared by clr
        wr(0, ADR_CTRL, 32'h2);
        rd_chk(0, ADR_STATUS, 32'h0, "clr_to_idle");
        smp(4'hA, 4'hA, 1'b0, 1'b0, 4'h1, 1'b0);
        idle(2);
        rd_chk(0, ADR_STATUS, 32'h8, "fault_idle_status");
        rd_chk(0, ADR_SMP_CNT, 0, "idle_no_count");
        wr(0, ADR_CTRL, 32'h3);
        rd_chk(0, ADR_STATUS, 32'h1, "clr_fault_status");
        smp(4'hA, 4'hA, 1'b0, 1'b0, 4'h1, 1'b0);
        idle(2);
        rd_chk(0, ADR_STATUS, 32'h9, "fault_armed_status");
        rd_chk(0, ADR_MIS_CNT, 0, "fault_mis_cnt");
        rd_chk(0, ADR_SMP_CNT, 1, "fault_smp_cnt");
        wr(0, ADR_CTRL, 32'h3);
        rd_chk(0, ADR_STATUS, 32'h1, "fault_cleared");

        // six mismatches without a trip: history overflow
        for (int i = 1; i <= 3; i++) smp_mis(4'(i), 4'h0);
        smp(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 4; i <= 6; i++) smp_mis(4'(i), 4'h0);
        idle(2);
        rd_chk(0, ADR_MIS_CNT, 6, "hist_mis_cnt");
`ifdef ALU_MON_HIST_EN
        rd_chk(0, ADR_STATUS, 32'h11, "hist_ovf_status");
        for (int i = 1; i <= 4; i++)
            rd_chk(0, ADR_HIST, 32'h8000_0000 | (32'(i) << 11) | (32'(i) << 1), "hist_entry");
        rd_chk(0, ADR_HIST, 32'h0, "hist_empty");
`else
        rd_chk(0, ADR_STATUS, 32'h1, "nohist_status");
        rd_chk(0, ADR_HIST, 32'h0, "nohist_read");
`endif

        // CNT_W=4 instance: counters saturate at 4'hF
        wr(1, ADR_CTRL, 32'h3);
        repeat (14) smp_mis(4'h1, 4'h2);
        smp(4'h6, 4'h6, 1'b0, 1'b0, 4'h0, 1'b0);
        repeat (6) smp_mis(4'h1, 4'h2);
        idle(2);
        rd_chk(1, ADR_MIS_CNT, 32'hF, "sat_mis_cnt");
        rd_chk(1, ADR_SMP_CNT, 32'hF, "sat_smp_cnt");
        rd_chk(1, ADR_FIRST_FAIL, 32'h0000_0481, "sat_first_fail");
        rd_chk(1, ADR_STATUS, 32'h1, "sat_status");
        check("sat_err", 32'(err2), 0);
        check("sat_irq", 32'(irq2), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
